clock_enable_gen: RTL and testbench
===================================

Name: clock_enable_gen

Overview:
- Sits directly downstream of the 50→56 MHz DCM stage and consumes its clock56 and locked outputs.
- Generates the system reset from DCM lock status.
- Generates all single-cycle clock-enable strobes for the ZX core: 7 MHz pixel enables and CPU enables.
- CPU enables have selectable turbo rates and ULA contention stretching.
- Every other block runs on clock56 and uses these enables; no derived clocks exist anywhere.

Parameters:
- LOCK_HOLD, 16, clock56 cycles that synchronised locked must stay high before rst_out releases (range 2..255).

Ports:
- clock56  in  1  56 MHz system clock from the DCM.
- reset  in  1  synchronous, active-high reset.
- locked  in  1  DCM lock, asynchronous to clock56.
- turbo  in  2  CPU rate select: 0 = 3.5 MHz, 1 = 7 MHz, 2 = 14 MHz, 3 = reserved, treated as 0.
- contend  in  1  ULA contention request, sampled at CPU rising slots.
- rst_out  out  1  system reset to the core, active-high.
- phase  out  4  free-running phase counter.
- ce7p  out  1  pixel enable, rising.
- ce7n  out  1  pixel enable, falling.
- cpu_p  out  1  CPU clock enable, rising.
- cpu_n  out  1  CPU clock enable, falling.
- stretched  out  1  high while the CPU clock is held by contention.

Behaviour:
- Interface: one clock, clock56. reset is synchronous and active-high. All state changes occur on the rising edge of clock56.
- Lock synchroniser: 2-flop synchroniser on locked gives lk_s, with 2-cycle latency.
- Lock counter: 8-bit lock_cnt clears whenever reset=1 or lk_s=0, and otherwise increments, saturating at LOCK_HOLD.
- rst_out: equals 1 while lock_cnt < LOCK_HOLD.
  - Release is LOCK_HOLD+2 cycles after locked rises.
  - If locked drops or reset pulses mid-operation, rst_out reasserts on the following cycle.
- Reset values (rst_out=1): phase=0, turbo_q=0, stretch state clear, and ce7p, ce7n, cpu_p, cpu_n, stretched all 0.
- phase: increments by 1 every cycle while rst_out=0 and wraps 15→0. In the first cycle with rst_out=0, phase=0.
- Strobes: registered, decoded from next-phase, so each pulse is high exactly in the cycle where phase equals its slot. Each pulse is 1 cycle wide and is never asserted while rst_out=1.
- Pixel enables:
  - ce7p when phase[2:0]=0.
  - ce7n when phase[2:0]=4.
- Turbo latching: turbo is latched into turbo_q only in the cycle where phase=15. Mid-period changes take effect at the next phase=0, so there are no short or double pulses.
- CPU slots by turbo_q:
  - 0: P slot at phase=0, N slot at phase=8.
  - 1: P slot at phase[2:0]=0, N slot at phase[2:0]=4.
  - 2: P slot at phase[1:0]=0, N slot at phase[1:0]=2.
- Contention state machine, states RUN and HOLD:
  - RUN, P slot, contend=0: cpu_p=1, then the next N slot gives cpu_n=1.
  - RUN, P slot, contend=1: go to HOLD. cpu_p is suppressed, and the following N slot is suppressed too.
  - HOLD: each P slot re-samples contend. If contend=0, cpu_p=1 in that slot and go to RUN. If contend=1, stay in HOLD.
  - contend is ignored outside P slots.
- stretched: 1 in HOLD, 0 in RUN.
- N/P pairing: a cpu_n never occurs without a preceding cpu_p in the same period.
- Simultaneous events:
  - A turbo change and contention at the same phase=0: the new rate applies to the slot decode and contend is evaluated at that P slot.
  - reset asserted together with any strobe condition: reset wins and all outputs go to 0 next cycle.

Decomposition:
- Shared package zx_clk_pkg holds:
  - turbo encodings TURBO_3M5, TURBO_7M, TURBO_14M;
  - slot constants P/N per rate;
  - the phase width constant 4.
- One natural sub-module: reset_sync, containing the 2-flop locked synchroniser plus the lock_cnt/rst_out logic.
- Strobe and contention logic stay in the top module.

Test Plan:
- Lock release: locked=0 for 20 cycles, then 1, with LOCK_HOLD=16 → rst_out falls exactly 18 cycles after locked rises. The first free cycle has phase=0, ce7p=1, cpu_p=1.
- Free run at turbo=0: 64 cycles → ce7p at phases 0 and 8, ce7n at 4 and 12, cpu_p only at phase 0, cpu_n only at 8. Expect 8 ce7p and 4 cpu_p.
- Turbo switch: set turbo=2 at phase=5 → 3.5 MHz pattern continues until phase=15. From the next phase=0, cpu_p appears at phases 0, 4, 8, 12 and cpu_n at 2, 6, 10, 14.
- Contention at turbo=0: contend=1 across phase=0 for 2 periods, then 0 → no cpu_p/cpu_n for 32 cycles and stretched=1 from the cycle after the first suppressed slot. cpu_p resumes at the third phase=0, then cpu_n follows at phase=8.
- Lock loss mid-run: locked drops at phase=6 → rst_out=1 three cycles later, all strobes 0, phase held 0. Re-lock gives release after LOCK_HOLD+2 cycles.
- Synchronous reset: reset=1 for 1 cycle during HOLD → next cycle rst_out=1 and stretched=0. Release follows LOCK_HOLD cycles later, with locked steady.

Source files
------------

// File: rtl/zx_clk_pkg.sv
// rtl/zx_clk_pkg.sv - shared encodings and slot constants for the ZX clock-enable generator
package zx_clk_pkg;

    localparam int PHASE_W = 4;

    // CPU rate encodings; the reserved code 3 is folded onto TURBO_3M5 by turbo_norm
    typedef enum logic [1:0] {
        TURBO_3M5 = 2'd0,
        TURBO_7M  = 2'd1,
        TURBO_14M = 2'd2
    } turbo_e;

    typedef enum logic {
        CPU_RUN  = 1'b0,
        CPU_HOLD = 1'b1
    } cpu_state_e;

    localparam logic [PHASE_W-1:0] PHASE_LAST = 4'hF;

    // Pixel enable slots within each 8-phase half period
    localparam logic [PHASE_W-1:0] CE7_MASK   = 4'h7;
    localparam logic [PHASE_W-1:0] CE7_P_SLOT = 4'd0;
    localparam logic [PHASE_W-1:0] CE7_N_SLOT = 4'd4;

    // CPU slots per rate: a phase hits when (phase & mask) == slot
    localparam logic [PHASE_W-1:0] MASK_3M5   = 4'hF;
    localparam logic [PHASE_W-1:0] P_SLOT_3M5 = 4'd0;
    localparam logic [PHASE_W-1:0] N_SLOT_3M5 = 4'd8;
    localparam logic [PHASE_W-1:0] MASK_7M    = 4'h7;
    localparam logic [PHASE_W-1:0] P_SLOT_7M  = 4'd0;
    localparam logic [PHASE_W-1:0] N_SLOT_7M  = 4'd4;
    localparam logic [PHASE_W-1:0] MASK_14M   = 4'h3;
    localparam logic [PHASE_W-1:0] P_SLOT_14M = 4'd0;
    localparam logic [PHASE_W-1:0] N_SLOT_14M = 4'd2;

    function automatic turbo_e turbo_norm(input logic [1:0] t);
        case (t)
            2'd1:    return TURBO_7M;
            2'd2:    return TURBO_14M;
            default: return TURBO_3M5;
        endcase
    endfunction

    function automatic logic slot_hit(input logic [PHASE_W-1:0] ph,
                                      input logic [PHASE_W-1:0] mask,
                                      input logic [PHASE_W-1:0] slot);
        return (ph & mask) == slot;
    endfunction

endpackage

// File: rtl/reset_sync.sv
// rtl/reset_sync.sv - locked synchroniser and lock-hold counter producing the system reset
module reset_sync #(
    parameter int unsigned LOCK_HOLD = 16
) (
    input  logic clock56,
    input  logic reset,
    input  logic locked,
    output logic rst_out,
    output logic rst_next
);

    localparam logic [7:0] HOLD_CNT = 8'(LOCK_HOLD);

    logic       lk_meta_q;
    logic       lk_s_q;
    logic [7:0] lock_cnt_q;
    logic [7:0] lock_cnt_d;

    // Two-flop synchroniser; left unreset so a reset pulse does not add sync latency
    always_ff @(posedge clock56) begin
        lk_meta_q <= locked;
        lk_s_q    <= lk_meta_q;
    end

    // Count up while lock is stable, saturating at the hold threshold
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (reset || !lk_s_q) begin
            lock_cnt_d = '0;
        end else if (lock_cnt_q < HOLD_CNT) begin
            lock_cnt_d = lock_cnt_q + 8'd1;
        end
    end

    // Lock counter register
    always_ff @(posedge clock56) begin
        if (reset) begin
            lock_cnt_q <= '0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // rst_next lets the strobe logic clear its registers in the same edge rst_out rises
    assign rst_out  = (lock_cnt_q < HOLD_CNT);
    assign rst_next = (lock_cnt_d < HOLD_CNT);

endmodule

// File: rtl/clock_enable_gen.sv
// rtl/clock_enable_gen.sv - phase counter, pixel/CPU clock enables and ULA contention stretch
module clock_enable_gen
    import zx_clk_pkg::*;
#(
    parameter int unsigned LOCK_HOLD = 16
) (
    input  logic               clock56,
    input  logic               reset,
    input  logic               locked,
    input  logic [1:0]         turbo,
    input  logic               contend,
    output logic               rst_out,
    output logic [PHASE_W-1:0] phase,
    output logic               ce7p,
    output logic               ce7n,
    output logic               cpu_p,
    output logic               cpu_n,
    output logic               stretched
);

    logic               rst_next;
    logic [PHASE_W-1:0] phase_q, phase_d;
    turbo_e             turbo_q, turbo_d;
    cpu_state_e         state_q, state_d;
    logic               ce7p_q, ce7p_d;
    logic               ce7n_q, ce7n_d;
    logic               cpu_p_q, cpu_p_d;
    logic               cpu_n_q, cpu_n_d;
    logic               stretched_q, stretched_d;
    logic               p_slot, n_slot;

    reset_sync #(
        .LOCK_HOLD (LOCK_HOLD)
    ) u_reset_sync (
        .clock56  (clock56),
        .reset    (reset),
        .locked   (locked),
        .rst_out  (rst_out),
        .rst_next (rst_next)
    );

    // Next phase, latched rate and contention FSM; strobes decode the next phase so they register aligned
    always_comb begin
        phase_d     = phase_q + 4'd1;
        turbo_d     = turbo_q;
        state_d     = state_q;
        ce7p_d      = 1'b0;
        ce7n_d      = 1'b0;
        cpu_p_d     = 1'b0;
        cpu_n_d     = 1'b0;
        stretched_d = 1'b0;
        p_slot      = 1'b0;
        n_slot      = 1'b0;

        if (rst_out) begin
            phase_d = '0;
        end
        if (phase_q == PHASE_LAST) begin
            turbo_d = turbo_norm(turbo);
        end

        case (turbo_d)
            TURBO_7M: begin
                p_slot = slot_hit(phase_d, MASK_7M, P_SLOT_7M);
                n_slot = slot_hit(phase_d, MASK_7M, N_SLOT_7M);
            end
            TURBO_14M: begin
                p_slot = slot_hit(phase_d, MASK_14M, P_SLOT_14M);
                n_slot = slot_hit(phase_d, MASK_14M, N_SLOT_14M);
            end
            default: begin
                p_slot = slot_hit(phase_d, MASK_3M5, P_SLOT_3M5);
                n_slot = slot_hit(phase_d, MASK_3M5, N_SLOT_3M5);
            end
        endcase

        if (rst_next) begin
            phase_d = '0;
            turbo_d = TURBO_3M5;
            state_d = CPU_RUN;
        end else begin
            ce7p_d      = slot_hit(phase_d, CE7_MASK, CE7_P_SLOT);
            ce7n_d      = slot_hit(phase_d, CE7_MASK, CE7_N_SLOT);
            stretched_d = (state_q == CPU_HOLD);
            if (p_slot) begin
                if (contend) begin
                    state_d = CPU_HOLD;
                end else begin
                    state_d = CPU_RUN;
                    cpu_p_d = 1'b1;
                end
            end
            // An N slot only fires once its P slot went through, keeping P/N paired
            if (n_slot && (state_q == CPU_RUN)) begin
                cpu_n_d = 1'b1;
            end
        end
    end

    // State and strobe registers
    always_ff @(posedge clock56) begin
        if (reset) begin
            phase_q     <= '0;
            turbo_q     <= TURBO_3M5;
            state_q     <= CPU_RUN;
            ce7p_q      <= 1'b0;
            ce7n_q      <= 1'b0;
            cpu_p_q     <= 1'b0;
            cpu_n_q     <= 1'b0;
            stretched_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            turbo_q     <= turbo_d;
            state_q     <= state_d;
            ce7p_q      <= ce7p_d;
            ce7n_q      <= ce7n_d;
            cpu_p_q     <= cpu_p_d;
            cpu_n_q     <= cpu_n_d;
            stretched_q <= stretched_d;
        end
    end

    assign phase     = phase_q;
    assign ce7p      = ce7p_q;
    assign ce7n      = ce7n_q;
    assign cpu_p     = cpu_p_q;
    assign cpu_n     = cpu_n_q;
    assign stretched = stretched_q;

endmodule

// File: tb/tb_clock_enable_gen.sv
// tb/tb_clock_enable_gen.sv - scoreboard bench for clock_enable_gen
module tb_clock_enable_gen;

    localparam int LH = 16;

    logic       clock56 = 1'b0;
    logic       reset;
    logic       locked;
    logic [1:0] turbo;
    logic       contend;
    logic       rst_out;
    logic [3:0] phase;
    logic       ce7p, ce7n, cpu_p, cpu_n, stretched;

    clock_enable_gen #(.LOCK_HOLD(LH)) dut (
        .clock56   (clock56),
        .reset     (reset),
        .locked    (locked),
        .turbo     (turbo),
        .contend   (contend),
        .rst_out   (rst_out),
        .phase     (phase),
        .ce7p      (ce7p),
        .ce7n      (ce7n),
        .cpu_p     (cpu_p),
        .cpu_n     (cpu_n),
        .stretched (stretched)
    );

    always #5 clock56 = ~clock56;

    typedef struct packed {
        logic       rst;
        logic [3:0] ph;
        logic       ce7p;
        logic       ce7n;
        logic       cpu_p;
        logic       cpu_n;
        logic       str;
    } exp_t;

    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    bit m_s1, m_s2, m_rst, m_hold;
    int m_cnt, m_phase, m_rate;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, want);
        end
    endtask

    // Predict the next cycle's outputs from current inputs, advance one edge, compare
    task automatic step();
        exp_t e;
        int   ns1, ns2, ncnt, nph, nrate, nhold, per;
        bit   nrst, p, n;
        ns1  = locked;
        ns2  = m_s1;
        ncnt = (reset || !m_s2) ? 0 : ((m_cnt < LH) ? m_cnt + 1 : m_cnt);
        nrst = (ncnt < LH);
        e    = '0;
        e.rst = nrst;
        if (nrst) begin
            nph = 0; nrate = 0; nhold = 0;
        end else begin
            nph   = m_rst ? 0 : (m_phase + 1) % 16;
            nrate = (!m_rst && m_phase == 15) ? ((turbo == 2'd3) ? 0 : int'(turbo)) : m_rate;
            per   = 16 >> nrate;
            p     = (nph % per) == 0;
            n     = (nph % per) == per / 2;
            e.ph   = 4'(nph);
            e.ce7p = (nph % 8) == 0;
            e.ce7n = (nph % 8) == 4;
            e.str  = m_hold;
            nhold  = m_hold;
            if (p) begin
                nhold   = contend;
                e.cpu_p = !contend;
            end
            if (n) e.cpu_n = !m_hold;
        end
        exp_q.push_back(e);
        @(posedge clock56);
        #1;
        e = exp_q.pop_front();
        check_eq("rst_out",   rst_out,   e.rst);
        check_eq("phase",     phase,     e.ph);
        check_eq("ce7p",      ce7p,      e.ce7p);
        check_eq("ce7n",      ce7n,      e.ce7n);
        check_eq("cpu_p",     cpu_p,     e.cpu_p);
        check_eq("cpu_n",     cpu_n,     e.cpu_n);
        check_eq("stretched", stretched, e.str);
        m_s1 = ns1[0]; m_s2 = ns2[0]; m_cnt = ncnt; m_rst = nrst;
        m_phase = nph; m_rate = nrate; m_hold = nhold[0];
    endtask

    task automatic wait_phase(input int target);
        bit hit = 0;
        for (int i = 0; i < 64; i++) begin
            if (phase == 4'(target)) begin
                hit = 1;
                break;
            end
            step();
        end
        check_eq("wait_phase", 32'(hit), 32'd1);
    endtask

    task automatic wait_release(input string tag, input int want);
        int k = 0;
        while (rst_out && k < 64) begin
            step();
            k++;
        end
        check_eq(tag, k, want);
    endtask

    initial begin
        int c_ce7p, c_ce7n, c_cp, c_cn, c_str;
        reset = 1'b1; locked = 1'b0; turbo = 2'd0; contend = 1'b0;
        repeat (3) @(posedge clock56);
        #1;
        m_s1 = 0; m_s2 = 0; m_cnt = 0; m_rst = 1; m_phase = 0; m_rate = 0; m_hold = 0;

        // Reset state
        step();

        // Lock release: 20 cycles unlocked, then locked=1
        reset = 1'b0;
        repeat (20) step();
        locked = 1'b1;
        wait_release("release_latency", LH + 2);
        check_eq("first_phase", phase, 0);
        check_eq("first_ce7p", ce7p, 1);
        check_eq("first_cpu_p", cpu_p, 1);

        // Free run at 3.5 MHz
        c_ce7p = 0; c_ce7n = 0; c_cp = 0; c_cn = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            c_ce7p += int'(ce7p); c_ce7n += int'(ce7n);
            c_cp += int'(cpu_p); c_cn += int'(cpu_n);
        end
        check_eq("run_ce7p_cnt", c_ce7p, 8);
        check_eq("run_ce7n_cnt", c_ce7n, 8);
        check_eq("run_cpu_p_cnt", c_cp, 4);
        check_eq("run_cpu_n_cnt", c_cn, 4);

        // Turbo switch to 14 MHz at phase 5
        wait_phase(5);
        turbo = 2'd2;
        c_cp = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            c_cp += int'(cpu_p);
        end
        check_eq("pre_switch_cpu_p", c_cp, 0);
        c_cp = 0; c_cn = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            c_cp += int'(cpu_p); c_cn += int'(cpu_n);
        end
        check_eq("t14_cpu_p_cnt", c_cp, 4);
        check_eq("t14_cpu_n_cnt", c_cn, 4);

        // Back to 3.5 MHz, then contention across two phase-0 slots
        turbo = 2'd0;
        repeat (20) step();
        wait_phase(15);
        contend = 1'b1;
        c_cp = 0; c_cn = 0; c_str = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            if (i == 16) contend = 1'b0;
            c_cp += int'(cpu_p); c_cn += int'(cpu_n); c_str += int'(stretched);
        end
        check_eq("hold_cpu_p_cnt", c_cp, 0);
        check_eq("hold_cpu_n_cnt", c_cn, 0);
        check_eq("hold_stretch_cnt", c_str, 31);
        step();
        check_eq("resume_cpu_p", cpu_p, 1);
        repeat (8) step();
        check_eq("resume_cpu_n", cpu_n, 1);

        // Lock loss at phase 6, then re-lock
        wait_phase(6);
        locked = 1'b0;
        repeat (3) step();
        check_eq("lockloss_rst", rst_out, 1);
        check_eq("lockloss_phase", phase, 0);
        repeat (5) step();
        locked = 1'b1;
        wait_release("relock_latency", LH + 2);

        // Synchronous reset while in HOLD
        wait_phase(15);
        contend = 1'b1;
        step();
        contend = 1'b0;
        step();
        check_eq("in_hold", stretched, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("sreset_rst", rst_out, 1);
        check_eq("sreset_stretched", stretched, 0);
        wait_release("sreset_latency", LH);

        // Randomised turbo/contend traffic with occasional lock drops
        for (int i = 0; i < 400; i++) begin
            turbo   = 2'($urandom_range(0, 3));
            contend = ($urandom_range(0, 3) == 0);
            locked  = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
